// File: rtl/vrf_bank_read_responder.sv
// rtl/vrf_bank_read_responder.sv - VRF bank responder: arbitrates two read pipes and one write port onto a single-port SRAM
//
// Purpose:
//    Accepts read requests from two read pipes and writes from one write port,
//    issuing at most one SRAM access per cycle. Read data returns to the granted
//    port with a fixed latency of two cycles after the request handshake.
//
// Ports:
//    clock, reset                 clock; synchronous active-high reset
//    rd{0,1}_valid / _ready       read request handshake
//    rd{0,1}_vs / _offset         read address (register index, word offset)
//    rd{0,1}_readSource           source tag, carried by the read pipe
//    rd{0,1}_instructionIndex     instruction tag, carried by the read pipe
//    rd{0,1}_result / _valid      read data and one-cycle completion pulse
//    wr_valid / wr_ready          write handshake
//    wr_vs, wr_offset             write address
//    wr_data, wr_mask             write data and byte enables
//    sram_en, sram_we             SRAM access enable and write enable
//    sram_addr                    SRAM word address {vs, offset}
//    sram_wdata, sram_wmask       SRAM write data and byte mask
//    sram_rdata                   SRAM read data, valid the cycle after a read

module vrf_bank_read_responder #(
   parameter int DATA_WIDTH   = 32,
   parameter int VS_WIDTH     = 5,
   parameter int OFFSET_WIDTH = 7,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                             clock,
   input  logic                             reset,

   input  logic                             rd0_valid,
   output logic                             rd0_ready,
   input  logic [VS_WIDTH-1:0]              rd0_vs,
   input  logic [OFFSET_WIDTH-1:0]          rd0_offset,
   input  logic [1:0]                       rd0_readSource,
   input  logic [2:0]                       rd0_instructionIndex,
   output logic [DATA_WIDTH-1:0]            rd0_result,
   output logic                             rd0_result_valid,

   input  logic                             rd1_valid,
   output logic                             rd1_ready,
   input  logic [VS_WIDTH-1:0]              rd1_vs,
   input  logic [OFFSET_WIDTH-1:0]          rd1_offset,
   input  logic [1:0]                       rd1_readSource,
   input  logic [2:0]                       rd1_instructionIndex,
   output logic [DATA_WIDTH-1:0]            rd1_result,
   output logic                             rd1_result_valid,

   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [VS_WIDTH-1:0]              wr_vs,
   input  logic [OFFSET_WIDTH-1:0]          wr_offset,
   input  logic [DATA_WIDTH-1:0]            wr_data,
   input  logic [DATA_WIDTH/8-1:0]          wr_mask,

   output logic                             sram_en,
   output logic                             sram_we,
   output logic [VS_WIDTH+OFFSET_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0]            sram_wdata,
   output logic [DATA_WIDTH/8-1:0]          sram_wmask,
   input  logic [DATA_WIDTH-1:0]            sram_rdata
);

   localparam logic [3:0] STARVE_THRESHOLD = 4'(STARVE_LIMIT);

   logic [3:0]            starve_count;
   logic                  starve;
   logic                  read_pending;
   logic                  write_fire;
   logic                  read_fire;
   logic                  grant_port;
   logic                  last_grant;
   logic                  s1_v;
   logic                  s1_port;
   logic                  result_valid0;
   logic                  result_valid1;
   logic [DATA_WIDTH-1:0] result0;
   logic [DATA_WIDTH-1:0] result1;

   // The tags travel alongside the request inside the read pipe; the bank
   // never needs to look at them.
   logic unused_tags;
   assign unused_tags = ^{rd0_readSource, rd0_instructionIndex,
                          rd1_readSource, rd1_instructionIndex};

   always_comb begin
      read_pending = rd0_valid | rd1_valid;
      starve       = (starve_count >= STARVE_THRESHOLD);

      // Writes take the slot unless reads have been starved long enough.
      write_fire = ~reset & wr_valid & ~(starve & read_pending);
      read_fire  = ~reset & read_pending & (~wr_valid | starve);

      // With both ports asking, hand the slot to whichever did not win last.
      grant_port = (rd0_valid & rd1_valid) ? ~last_grant : rd1_valid;

      wr_ready  = write_fire;
      rd0_ready = read_fire & ~grant_port;
      rd1_ready = read_fire & grant_port;

      sram_en    = write_fire | read_fire;
      sram_we    = write_fire;
      sram_wdata = wr_data;
      sram_wmask = wr_mask;
      if (write_fire) begin
         sram_addr = {wr_vs, wr_offset};
      end else if (grant_port) begin
         sram_addr = {rd1_vs, rd1_offset};
      end else begin
         sram_addr = {rd0_vs, rd0_offset};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_count  <= 4'd0;
         last_grant    <= 1'b1;
         s1_v          <= 1'b0;
         s1_port       <= 1'b0;
         result_valid0 <= 1'b0;
         result_valid1 <= 1'b0;
         result0       <= '0;
         result1       <= '0;
      end else begin
         if (read_fire) begin
            starve_count <= 4'd0;
            last_grant   <= grant_port;
         end else if (!read_pending) begin
            starve_count <= 4'd0;
         end else if (write_fire && starve_count != 4'hF) begin
            starve_count <= starve_count + 4'd1;
         end

         // Stage 1: remember who owns the SRAM read issued this cycle.
         s1_v    <= read_fire;
         s1_port <= grant_port;

         // Stage 2: SRAM data is now valid; steer it to the owning port.
         result_valid0 <= s1_v & ~s1_port;
         result_valid1 <= s1_v & s1_port;
         if (s1_v && !s1_port) begin
            result0 <= sram_rdata;
         end
         if (s1_v && s1_port) begin
            result1 <= sram_rdata;
         end
      end
   end

   // Completion pulses are suppressed while reset is held so that a read
   // caught in flight never reports.
   assign rd0_result_valid = result_valid0 & ~reset;
   assign rd1_result_valid = result_valid1 & ~reset;
   assign rd0_result       = result0;
   assign rd1_result       = result1;

endmodule

// File: doc/vrf_bank_read_responder.md
# vrf_bank_read_responder

Responder side of the VRF read-request protocol for one VRF bank. It accepts read requests from two read pipes (port 0 = primary, port 1 = contender) and one write port, and drives a single-port SRAM macro. Read data returns to the granted port exactly 2 cycles after the request handshake, matching the fixed 2-stage result pipe in the requesting read pipe. It sits between the lane's read pipes and the bank SRAM.

## Interface
- DATA_WIDTH, 32, data word width
- VS_WIDTH, 5, vector register index width
- OFFSET_WIDTH, 7, word offset within a register; SRAM address = {vs, offset}, 12 bits
- STARVE_LIMIT, 4, consecutive write-blocked cycles with a read pending before reads win priority (range 1..15)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd{0,1}_valid  in  1  read request valid
- rd{0,1}_ready  out  1  read request accepted this cycle
- rd{0,1}_vs  in  5  register index
- rd{0,1}_offset  in  7  word offset
- rd{0,1}_readSource  in  2  source tag (carried, not interpreted)
- rd{0,1}_instructionIndex  in  3  instruction tag (carried, not interpreted)
- rd{0,1}_result  out  32  read data for that port
- rd{0,1}_result_valid  out  1  one-cycle pulse when rd*_result is new
- wr_valid / wr_ready  in / out  1  write handshake
- wr_vs, wr_offset, wr_data, wr_mask  in  5, 7, 32, 4  write address, data, byte enables
- sram_en, sram_we  out  1  SRAM access enable, write enable
- sram_addr  out  12  {vs, offset}
- sram_wdata, sram_wmask  out  32, 4  write data, byte mask
- sram_rdata  in  32  read data, valid the cycle after sram_en & ~sram_we

## Operation
- One SRAM access per cycle. Arbitration order each cycle:
  - starve flag set: reads first;
  - otherwise a write first;
  - among reads, round-robin.
- Write wins: wr_ready=1, both rd*_ready=0, sram_en=sram_we=1, sram_wmask=wr_mask.
- Read wins: grant one port. If only one port is valid, grant it. If both are valid, grant the port other than last_grant. last_grant updates on every read handshake; it resets to 1 so port 0 wins first.
- A granted read drives sram_en=1, sram_we=0, sram_addr={vs,offset}.
- rd*_ready and wr_ready are combinational from the valids and the starve flag. At most one of rd0_ready, rd1_ready, wr_ready is high per cycle. A ready never asserts for a deasserted valid.
- Starve counter, 4 bits:
  - increments when a write fires while any rd*_valid is high;
  - clears on any read handshake, or when no read is pending;
  - starve flag = counter >= STARVE_LIMIT;
  - while the flag is set, wr_ready=0 if any read is pending.
- Pipeline tags:
  - s1_v and s1_port are registered at the handshake cycle;
  - s2 registers sram_rdata into result[s1_port] and pulses result_valid[s1_port].
- rd*_result holds its last value until that port's next read completes.
- Read/write ordering is program order of SRAM access. A read accepted at cycle t sees every write accepted before t and none accepted at t or later. No bypass.

## Timing
- Read handshake at cycle t, then SRAM read at t, sram_rdata at t+1, rd*_result and result_valid at t+2. Fixed latency 2, no backpressure on results.
- Throughput: 1 read or 1 write per cycle. Back-to-back reads on alternating ports pipeline fully.
- Reset values:
  - all ready, result_valid and sram_en outputs = 0 during reset;
  - rd*_result = 0;
  - s1_v = 0, last_grant = 1, starve counter = 0.
- Reset mid-operation: in-flight reads are dropped and no result_valid is issued for them. The first cycle after reset deassertion behaves as a fresh start.
- Simultaneous wr_valid, rd0_valid and rd1_valid with no starve flag: the write fires, and the reads wait.

## Test plan
- Write {vs=3,off=5} data 0xDEADBEEF mask 0xF, then rd0 reads {3,5} at cycle t -> rd0_result=0xDEADBEEF, rd0_result_valid at t+2 only; rd1_result unchanged.
- rd0 and rd1 both valid continuously for 4 cycles with no writes -> grants 0,1,0,1; results pulse on the alternate ports at t+2 each.
- Partial write: word 0x11223344, then write 0xAABBCCDD with mask 0b0101 -> readback 0x11BB33DD.
- wr_valid held high with rd0_valid high and STARVE_LIMIT=4 -> 4 writes fire, cycle 5 rd0 fires with wr_ready=0, then writes resume.
- Write and read of the same address in the same cycle -> write fires first; the read fires next cycle and returns the new data.
- Assert reset the cycle after a read handshake -> no result_valid pulse; rd*_result=0; first post-reset request is served with latency 2.
